// File: rtl/vrf_port_arbiter.sv
// VRF port arbiter: round-robin write-port sharing (ALU/VLD) and read sequencing.
// Define VRF_FWD_EN to forward same-cycle write data instead of stalling the read.
module vrf_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wr_valid,
  output logic              alu_wr_ready,
  input  logic [ADDR_W-1:0] alu_wr_addr,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              vld_wr_valid,
  output logic              vld_wr_ready,
  input  logic [ADDR_W-1:0] vld_wr_addr,
  input  logic [DATA_W-1:0] vld_wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [ADDR_W-1:0] vrf_aa,
  output logic [ADDR_W-1:0] vrf_ab,
  output logic [ADDR_W-1:0] vrf_ac,
  output logic [DATA_W-1:0] vrf_dc,
  output logic              vrf_valid_dc,
  input  logic [DATA_W-1:0] vrf_da,
  input  logic [DATA_W-1:0] vrf_db
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              alu_pri;
  logic              gnt_alu;
  logic              gnt_vld;
  logic              gnt;
  logic [ADDR_W-1:0] ac_q;
  logic [DATA_W-1:0] dc_q;
  logic [ADDR_W-1:0] aa_q;
  logic [ADDR_W-1:0] ab_q;
  logic [DATA_W-1:0] hold_a;
  logic [DATA_W-1:0] hold_b;
  logic [DATA_W-1:0] resp_a;
  logic [DATA_W-1:0] resp_b;
  logic              hit_a;
  logic              hit_b;
  logic              hazard;
  logic              open;
  logic              accept;

  // Grants are qualified by rst so every ready drops while reset is held.
  always_comb begin
    gnt_alu = rst & alu_wr_valid & (alu_pri | ~vld_wr_valid);
    gnt_vld = rst & vld_wr_valid & ~gnt_alu;
    gnt     = gnt_alu | gnt_vld;
  end

  assign alu_wr_ready = gnt_alu;
  assign vld_wr_ready = gnt_vld;
  assign vrf_valid_dc = gnt;

  always_comb begin
    vrf_ac = ac_q;
    vrf_dc = dc_q;
    unique case (1'b1)
      gnt_alu: begin
        vrf_ac = alu_wr_addr;
        vrf_dc = alu_wr_data;
      end
      gnt_vld: begin
        vrf_ac = vld_wr_addr;
        vrf_dc = vld_wr_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_pri <= 1'b1;
      ac_q    <= '0;
      dc_q    <= '0;
    end else if (gnt) begin
      alu_pri <= gnt_vld;
      ac_q    <= vrf_ac;
      dc_q    <= vrf_dc;
    end
  end

  assign hit_a  = gnt & (vrf_ac == rd_addr_a);
  assign hit_b  = gnt & (vrf_ac == rd_addr_b);
  assign hazard = hit_a | hit_b;

  // A new read may only enter when the response slot drains this cycle.
  assign open = rst & ((state == IDLE) |
                       ((state == RESP) & rd_resp_ready));

`ifdef VRF_FWD_EN
  assign rd_ready = open;
`else
  assign rd_ready = open & ~hazard;
`endif

  assign accept = rd_valid & rd_ready;
  assign vrf_aa = rd_ready ? rd_addr_a : aa_q;
  assign vrf_ab = rd_ready ? rd_addr_b : ab_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aa_q <= '0;
      ab_q <= '0;
    end else if (rd_ready) begin
      aa_q <= rd_addr_a;
      ab_q <= rd_addr_b;
    end
  end

`ifdef VRF_FWD_EN
  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] fwd_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a <= 1'b0;
      fwd_b <= 1'b0;
      fwd_d <= '0;
    end else begin
      fwd_a <= accept & hit_a;
      fwd_b <= accept & hit_b;
      fwd_d <= vrf_dc;
    end
  end

  assign resp_a = fwd_a ? fwd_d : vrf_da;
  assign resp_b = fwd_b ? fwd_d : vrf_db;
`else
  assign resp_a = vrf_da;
  assign resp_b = vrf_db;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE: state_nxt = accept ? RESP : IDLE;
      RESP: begin
        if (!rd_resp_ready) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = accept ? RESP : IDLE;
        end
      end
      HOLD: state_nxt = rd_resp_ready ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot at the stall so later writes cannot alter the held operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_a <= '0;
      hold_b <= '0;
    end else if ((state == RESP) && !rd_resp_ready) begin
      hold_a <= resp_a;
      hold_b <= resp_b;
    end
  end

  always_comb begin
    rd_resp_valid = 1'b0;
    rd_data_a     = resp_a;
    rd_data_b     = resp_b;
    unique case (state)
      RESP: rd_resp_valid = 1'b1;
      HOLD: begin
        rd_resp_valid = 1'b1;
        rd_data_a     = hold_a;
        rd_data_b     = hold_b;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vrf_port_arbiter.sv
// Testbench for vrf_port_arbiter: VRF memory model plus behavioural reference.
// Directed steps followed by a randomized phase; all outputs checked each cycle.
module tb_vrf_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_wr_valid, alu_wr_ready;
  logic [AW-1:0] alu_wr_addr;
  logic [DW-1:0] alu_wr_data;
  logic          vld_wr_valid, vld_wr_ready;
  logic [AW-1:0] vld_wr_addr;
  logic [DW-1:0] vld_wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          rd_resp_valid, rd_resp_ready;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [AW-1:0] vrf_aa, vrf_ab, vrf_ac;
  logic [DW-1:0] vrf_dc;
  logic          vrf_valid_dc;
  logic [DW-1:0] vrf_da, vrf_db;

  always #5 clk = ~clk;

  vrf_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_wr_valid(alu_wr_valid), .alu_wr_ready(alu_wr_ready),
    .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
    .vld_wr_valid(vld_wr_valid), .vld_wr_ready(vld_wr_ready),
    .vld_wr_addr(vld_wr_addr), .vld_wr_data(vld_wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .vrf_aa(vrf_aa), .vrf_ab(vrf_ab), .vrf_ac(vrf_ac),
    .vrf_dc(vrf_dc), .vrf_valid_dc(vrf_valid_dc),
    .vrf_da(vrf_da), .vrf_db(vrf_db)
  );

  // VRF stand-in: registered read, write at the same edge (old data returned).
  logic [DW-1:0] vmem [0:1023];
  logic [DW-1:0] vda_q, vdb_q;
  logic          ovr;
  logic [DW-1:0] ovr_val;

  always @(posedge clk) begin
    vda_q <= vmem[vrf_aa];
    vdb_q <= vmem[vrf_ab];
    if (vrf_valid_dc) vmem[vrf_ac] <= vrf_dc;
  end

  assign vrf_da = ovr ? ovr_val : vda_q;
  assign vrf_db = ovr ? ~ovr_val : vdb_q;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0]   ref_mem [0:1023];
  logic [2*DW-1:0] exp_q [$];
  bit              last_alu;
  bit              resp_wait;
  bit              ac_known;
  logic [AW-1:0]   last_ac;
  bit              last_acc;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_alu  = 1'b0;
    resp_wait = 1'b0;
    ac_known  = 1'b0;
  endtask

  task automatic idle_in();
    alu_wr_valid  = 1'b0;
    vld_wr_valid  = 1'b0;
    rd_valid      = 1'b0;
    rd_resp_ready = 1'b1;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    bit            ga, gv, gw, haz, erdy, acc;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, ea, eb;
    logic [2*DW-1:0] fr;
    #1;
    ga = alu_wr_valid && (!vld_wr_valid || !last_alu);
    gv = vld_wr_valid && !ga;
    gw = ga || gv;
    wa = ga ? alu_wr_addr : vld_wr_addr;
    wd = ga ? alu_wr_data : vld_wr_data;
    haz = gw && (wa == rd_addr_a || wa == rd_addr_b);
`ifdef VRF_FWD_EN
    erdy = 1'b1;
`else
    erdy = !haz;
`endif
    if (exp_q.size() != 0 && (resp_wait || !rd_resp_ready)) erdy = 1'b0;
    chk("alu_ready", alu_wr_ready, ga);
    chk("vld_ready", vld_wr_ready, gv);
    chk("wr_en", vrf_valid_dc, gw);
    if (gw) begin
      chk("wr_addr", vrf_ac, wa);
      chk("wr_data", vrf_dc, wd);
    end else if (ac_known) begin
      chk("wr_addr_hold", vrf_ac, last_ac);
    end
    chk("rd_ready", rd_ready, erdy);
    if (erdy) begin
      chk("rd_aa", vrf_aa, rd_addr_a);
      chk("rd_ab", vrf_ab, rd_addr_b);
    end
    chk("resp_valid", rd_resp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      fr = exp_q[0];
      chk("resp_a", rd_data_a, fr[2*DW-1:DW]);
      chk("resp_b", rd_data_b, fr[DW-1:0]);
    end
    acc = rd_valid && erdy;
    ea = (gw && wa == rd_addr_a) ? wd : ref_mem[rd_addr_a];
    eb = (gw && wa == rd_addr_b) ? wd : ref_mem[rd_addr_b];
    if (exp_q.size() != 0) begin
      if (rd_resp_ready) begin
        void'(exp_q.pop_front());
        resp_wait = 1'b0;
      end else begin
        resp_wait = 1'b1;
      end
    end
    if (acc) exp_q.push_back({ea, eb});
    if (gw) begin
      ref_mem[wa] = wd;
      last_alu    = ga;
      last_ac     = wa;
      ac_known    = 1'b1;
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu_write(logic [AW-1:0] a, logic [DW-1:0] d);
    idle_in();
    alu_wr_valid = 1'b1;
    alu_wr_addr  = a;
    alu_wr_data  = d;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ovr = 1'b0;
    ovr_val = '0;
    alu_wr_addr = '0; alu_wr_data = '0;
    vld_wr_addr = '0; vld_wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    idle_in();
    alu_wr_valid = 1'b1;
    vld_wr_valid = 1'b1;
    rd_valid = 1'b1;
    model_reset();
    #1;
    chk("rst_alu_ready", alu_wr_ready, 1'b0);
    chk("rst_vld_ready", vld_wr_ready, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_resp_valid", rd_resp_valid, 1'b0);
    chk("rst_wr_en", vrf_valid_dc, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle_in();

    // Contention from reset: ALU, VLD, ALU, VLD.
    for (int i = 0; i < 4; i++) begin
      idle_in();
      alu_wr_valid = 1'b1; alu_wr_addr = 10'h010;
      alu_wr_data  = {$urandom, $urandom};
      vld_wr_valid = 1'b1; vld_wr_addr = 10'h020;
      vld_wr_data  = {$urandom, $urandom};
      cycle();
    end

    for (int i = 0; i < 64; i++) alu_write(AW'(i), {$urandom, $urandom});
    alu_write(10'h005, 64'hAA);
    alu_write(10'h006, 64'hBB);
    idle_in();
    cycle();

    // Single read then back-to-back reads.
    rd_valid = 1'b1; rd_addr_a = 10'h005; rd_addr_b = 10'h006;
    cycle();
    rd_valid = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 6; i++) begin
      rd_valid  = 1'b1;
      rd_addr_a = AW'($urandom_range(0, 15));
      rd_addr_b = AW'($urandom_range(0, 15));
      cycle();
    end
    rd_valid = 1'b0;
    cycle();
    cycle();

    // Consumer stalls 3 cycles while the VRF output wanders.
    rd_valid = 1'b1; rd_addr_a = 10'h005; rd_addr_b = 10'h006;
    cycle();
    rd_valid = 1'b0; rd_resp_ready = 1'b0;
    cycle();
    for (int i = 0; i < 2; i++) begin
      ovr = 1'b1; ovr_val = {$urandom, $urandom};
      cycle();
    end
    rd_resp_ready = 1'b1;
    cycle();
    ovr = 1'b0;
    cycle();

    // Same-cycle write/read hazard on 0x007.
    idle_in();
    alu_wr_valid = 1'b1; alu_wr_addr = 10'h007; alu_wr_data = 64'h1234;
    rd_valid = 1'b1; rd_addr_a = 10'h007; rd_addr_b = 10'h008;
    cycle();
    alu_wr_valid = 1'b0;
    for (int k = 0; k < 4 && !last_acc; k++) cycle();
    chk("haz_accepted", last_acc, 1'b1);
    rd_valid = 1'b0;
    cycle();
    cycle();

    // Reset while a response is stalled.
    rd_valid = 1'b1; rd_addr_a = 10'h003; rd_addr_b = 10'h004;
    cycle();
    rd_valid = 1'b0; rd_resp_ready = 1'b0;
    alu_wr_valid = 1'b1; alu_wr_addr = 10'h030; alu_wr_data = {$urandom, $urandom};
    vld_wr_valid = 1'b1; vld_wr_addr = 10'h031; vld_wr_data = {$urandom, $urandom};
    rst = 1'b0;
    #1;
    chk("arst_resp_valid", rd_resp_valid, 1'b0);
    chk("arst_alu_ready", alu_wr_ready, 1'b0);
    chk("arst_vld_ready", vld_wr_ready, 1'b0);
    chk("arst_rd_ready", rd_ready, 1'b0);
    chk("arst_wr_en", vrf_valid_dc, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rd_resp_ready = 1'b1;
    cycle();
    idle_in();
    for (int i = 0; i < 3; i++) cycle();

    // VLD alone three times, then contention.
    for (int i = 0; i < 3; i++) begin
      idle_in();
      vld_wr_valid = 1'b1; vld_wr_addr = AW'($urandom_range(0, 63));
      vld_wr_data  = {$urandom, $urandom};
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      alu_wr_valid = 1'b1; alu_wr_addr = AW'($urandom_range(0, 63));
      alu_wr_data  = {$urandom, $urandom};
      vld_wr_valid = 1'b1; vld_wr_addr = AW'($urandom_range(0, 63));
      vld_wr_data  = {$urandom, $urandom};
      cycle();
    end

    for (int i = 0; i < 500; i++) begin
      alu_wr_valid  = ($urandom_range(0, 2) != 0);
      alu_wr_addr   = AW'($urandom_range(0, 15));
      alu_wr_data   = {$urandom, $urandom};
      vld_wr_valid  = ($urandom_range(0, 2) != 0);
      vld_wr_addr   = AW'($urandom_range(0, 15));
      vld_wr_data   = {$urandom, $urandom};
      rd_valid      = ($urandom_range(0, 3) != 0);
      rd_addr_a     = AW'($urandom_range(0, 15));
      rd_addr_b     = AW'($urandom_range(0, 15));
      rd_resp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    idle_in();
    for (int i = 0; i < 3; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
